// File: rtl/bht_sram_ctrl.sv
// bht_sram_ctrl: clears, reads and read-modify-write updates a 1-port SRAM of saturating branch counters
module bht_sram_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int CTR_WIDTH = 2,
  parameter logic [CTR_WIDTH-1:0] INIT_VAL = 2'b01,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_req_valid,
  output logic                  pred_req_ready,
  input  logic [ADDR_WIDTH-1:0] pred_req_idx,
  output logic                  pred_resp_valid,
  output logic [CTR_WIDTH-1:0]  pred_resp_ctr,
  output logic                  pred_resp_taken,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [ADDR_WIDTH-1:0] upd_idx,
  input  logic                  upd_taken,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [CTR_WIDTH-1:0]  sram_din0,
  input  logic [CTR_WIDTH-1:0]  sram_dout0
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [CTR_WIDTH-1:0] CMAX = '1;
  typedef enum logic [1:0] {INIT, IDLE, UPD_MOD} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] upd_idx_q;
  logic                  upd_taken_q;
  logic                  upd_pending;
  logic [SW-1:0]         starve_cnt;
  logic                  pred_fire;
  logic                  upd_fire;
  logic                  grant;
  logic [CTR_WIDTH-1:0]  ctr_new;
  // The buffer frees up while its write is issued, so back-to-back updates cost 2 port cycles each
  assign upd_ready = init_done && (!upd_pending || state == UPD_MOD);
  assign pred_req_ready = init_done && state == IDLE && !(upd_pending && starve_cnt == SLIM);
  assign pred_fire = pred_req_valid && pred_req_ready;
  assign upd_fire = upd_valid && upd_ready;
  assign grant = state == IDLE && !pred_fire && upd_pending;
  assign pred_resp_ctr = sram_dout0;
  assign pred_resp_taken = sram_dout0[CTR_WIDTH-1];
  assign ctr_new = upd_taken_q ? (sram_dout0 == CMAX ? CMAX : sram_dout0 + CTR_WIDTH'(1))
                               : (sram_dout0 == '0 ? '0 : sram_dout0 - CTR_WIDTH'(1));
  always_comb begin
    sram_csb0 = !(state != IDLE || pred_fire || upd_pending);
    sram_web0 = state == IDLE;
    sram_addr0 = state == INIT ? init_cnt : pred_fire ? pred_req_idx : upd_pending ? upd_idx_q : '0;
    sram_din0 = state == INIT ? INIT_VAL : state == UPD_MOD ? ctr_new : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      init_cnt <= '0;
      init_done <= 1'b0;
      upd_pending <= 1'b0;
      upd_idx_q <= '0;
      upd_taken_q <= 1'b0;
      starve_cnt <= '0;
      pred_resp_valid <= 1'b0;
    end else begin
      pred_resp_valid <= pred_fire;
      init_cnt <= init_cnt + ADDR_WIDTH'(state == INIT);
      init_done <= init_done || (state == INIT && &init_cnt);
      state <= state == INIT ? (&init_cnt ? IDLE : INIT) : grant ? UPD_MOD : IDLE;
      upd_pending <= upd_fire || (upd_pending && state != UPD_MOD);
      starve_cnt <= (upd_pending && state == IDLE && !grant)
                    ? (starve_cnt == SLIM ? starve_cnt : starve_cnt + SW'(1)) : '0;
      if (upd_fire) begin
        upd_idx_q <= upd_idx;
        upd_taken_q <= upd_taken;
      end
    end
  end
endmodule

// File: tb/tb_bht_sram_ctrl.sv
// tb_bht_sram_ctrl: directed scoreboard bench for bht_sram_ctrl with a behavioural 512x2 SRAM
module tb_bht_sram_ctrl;
  logic       clk = 0;
  logic       rst_n = 1;
  logic       pred_req_valid = 0;
  logic       pred_req_ready;
  logic [8:0] pred_req_idx = 0;
  logic       pred_resp_valid;
  logic [1:0] pred_resp_ctr;
  logic       pred_resp_taken;
  logic       upd_valid = 0;
  logic       upd_ready;
  logic [8:0] upd_idx = 0;
  logic       upd_taken = 0;
  logic       init_done;
  logic       sram_csb0;
  logic       sram_web0;
  logic [8:0] sram_addr0;
  logic [1:0] sram_din0;
  logic [1:0] sram_dout0;

  bht_sram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pred_req_valid(pred_req_valid), .pred_req_ready(pred_req_ready), .pred_req_idx(pred_req_idx),
    .pred_resp_valid(pred_resp_valid), .pred_resp_ctr(pred_resp_ctr), .pred_resp_taken(pred_resp_taken),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clk = ~clk;

  // SRAM: a write captured at one edge lands at the next, before a read captured there
  logic [1:0] mem [0:511];
  logic       wp_v = 0;
  logic [8:0] wp_a;
  logic [1:0] wp_d;
  always @(posedge clk) begin
    if (wp_v) mem[wp_a] = wp_d;
    wp_v = 0;
    if (sram_csb0 === 1'b0) begin
      if (sram_web0 === 1'b0) begin
        wp_v = 1;
        wp_a = sram_addr0;
        wp_d = sram_din0;
      end else sram_dout0 <= mem[sram_addr0];
    end
  end

  logic [1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [1:0] e;
    if (rst_n && pred_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_unexpected: got ctr %0d with no response expected", pred_resp_ctr);
      end else begin
        e = exp_q.pop_front();
        chk("resp_ctr", {30'd0, pred_resp_ctr}, {30'd0, e});
        chk("resp_taken", {31'd0, pred_resp_taken}, {31'd0, e[1]});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic reset_dut(input string tag);
    rst_n = 0;
    #1;
    exp_q.delete();
    pred_req_valid = 0;
    upd_valid = 0;
    chk({tag, "_init_done"}, {31'd0, init_done}, 0);
    chk({tag, "_resp_valid"}, {31'd0, pred_resp_valid}, 0);
    chk({tag, "_pred_ready"}, {31'd0, pred_req_ready}, 0);
    chk({tag, "_upd_ready"}, {31'd0, upd_ready}, 0);
    chk({tag, "_csb0"}, {31'd0, sram_csb0}, 0);
    chk({tag, "_web0"}, {31'd0, sram_web0}, 0);
    chk({tag, "_addr0"}, {23'd0, sram_addr0}, 0);
    chk({tag, "_din0"}, {30'd0, sram_din0}, 1);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_init();
    repeat (511) @(posedge clk);
    @(negedge clk);
    chk("init_done_c512", {31'd0, init_done}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("init_done_c513", {31'd0, init_done}, 1);
    chk("idle_csb0", {31'd0, sram_csb0}, 1);
    chk("idle_web0", {31'd0, sram_web0}, 1);
    chk("idle_addr0", {23'd0, sram_addr0}, 0);
  endtask

  task automatic pred(input logic [8:0] idx, input logic [1:0] exp);
    int t = 0;
    @(negedge clk);
    pred_req_valid = 1;
    pred_req_idx = idx;
    #1;
    while (!pred_req_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (pred_req_ready) exp_q.push_back(exp);
    else chk("pred_ready_wait", {31'd0, pred_req_ready}, 1);
    @(posedge clk);
    #1 pred_req_valid = 0;
  endtask

  task automatic upd(input logic [8:0] idx, input logic tk);
    int t = 0;
    @(negedge clk);
    upd_valid = 1;
    upd_idx = idx;
    upd_taken = tk;
    #1;
    while (!upd_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!upd_ready) chk("upd_ready_wait", {31'd0, upd_ready}, 1);
    @(posedge clk);
    #1 upd_valid = 0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int acc, port, wr, acc2_c;
    logic [7:0] rdy_seq;
    @(posedge clk);
    #1 reset_dut("rst");
    wait_init();

    pred(0, 1);
    pred(255, 1);
    pred(511, 1);

    upd(5, 1); pred(5, 2);
    upd(5, 1); pred(5, 3);
    upd(5, 1); pred(5, 3);
    upd(5, 0); pred(5, 2);
    upd(5, 0); pred(5, 1);
    upd(5, 0); pred(5, 0);
    upd(5, 0); pred(5, 0);

    // back-to-back updates to idx 7
    @(negedge clk);
    upd_valid = 1; upd_idx = 7; upd_taken = 1;
    acc = 0; port = 0; wr = 0; acc2_c = -1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (!sram_csb0) port++;
      if (!sram_csb0 && !sram_web0) wr++;
      if (upd_valid && upd_ready) begin
        acc++;
        if (acc == 2) acc2_c = c;
      end
      @(posedge clk);
      #1 if (acc == 2) upd_valid = 0;
      @(negedge clk);
    end
    chk("b2b_accepts", acc, 2);
    chk("b2b_second_accept_cycle", acc2_c, 2);
    chk("b2b_port_cycles", port, 4);
    chk("b2b_write_cycles", wr, 2);
    pred(7, 3);

    // starvation: predicts every cycle while an update waits
    @(negedge clk);
    upd_valid = 1; upd_idx = 20; upd_taken = 1;
    pred_req_valid = 1; pred_req_idx = 0;
    rdy_seq = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      rdy_seq = {rdy_seq[6:0], pred_req_ready};
      if (c == 0) chk("starve_upd_accept", {31'd0, upd_ready}, 1);
      if (c == 4) chk("starve_cnt_3", {29'd0, dut.starve_cnt}, 3);
      if (c == 5) chk("starve_cnt_4", {29'd0, dut.starve_cnt}, 4);
      if (c == 7) chk("starve_cnt_clear", {29'd0, dut.starve_cnt}, 0);
      if (pred_req_valid && pred_req_ready) exp_q.push_back(1);
      @(posedge clk);
      #1 upd_valid = 0;
      @(negedge clk);
    end
    pred_req_valid = 0;
    chk("starve_ready_seq", {24'd0, rdy_seq}, 32'b11111001);
    pred(20, 2);

    // predict and update of idx 9 in the same cycle
    @(negedge clk);
    pred_req_valid = 1; pred_req_idx = 9;
    upd_valid = 1; upd_idx = 9; upd_taken = 1;
    #1;
    chk("same_pred_ready", {31'd0, pred_req_ready}, 1);
    chk("same_upd_ready", {31'd0, upd_ready}, 1);
    exp_q.push_back(1);
    @(posedge clk);
    #1 begin pred_req_valid = 0; upd_valid = 0; end
    repeat (3) @(posedge clk);
    pred(9, 2);
    repeat (3) @(posedge clk);

    // reset in the middle of init
    #1 reset_dut("rst_pre");
    repeat (100) @(posedge clk);
    #1 chk("init_addr_100", {23'd0, sram_addr0}, 100);
    reset_dut("rst_init100");
    wait_init();

    // reset in the middle of UPD_MOD
    @(negedge clk);
    upd_valid = 1; upd_idx = 30; upd_taken = 1;
    @(posedge clk);
    #1 upd_valid = 0;
    @(posedge clk);
    #1;
    chk("updmod_csb0", {31'd0, sram_csb0}, 0);
    chk("updmod_web0", {31'd0, sram_web0}, 0);
    chk("updmod_addr0", {23'd0, sram_addr0}, 30);
    reset_dut("rst_updmod");
    chk("rst_updmod_pending", {31'd0, dut.upd_pending}, 0);
    wait_init();
    for (int i = 0; i < 512; i++) pred(9'(i), 1);
    repeat (4) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
